// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin sharing of one external ALU with an issue/response pipeline.
// Define ALU_ILLEGAL_CHK_EN to flag illegal control codes via rsp_err.
module alu_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*32-1:0] req_in1,
    input  logic [NREQ*32-1:0] req_in2,
    input  logic [NREQ*5-1:0] req_ctl,
    input  logic [NREQ-1:0]   req_sign,
    output logic [31:0]       alu_in1,
    output logic [31:0]       alu_in2,
    output logic [4:0]        alu_ctl,
    output logic              alu_sign,
    input  logic [31:0]       alu_out,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [31:0]       rsp_data,
    output logic              rsp_zero,
    output logic              rsp_err
);
    logic [IDW-1:0] ptr, gnt_id, iss_id;
    logic           found, stall, xfer, ill, iss_v, iss_err;
    logic [31:0]    sel_in1, sel_in2;
    logic [4:0]     sel_ctl;
    logic           sel_sign;
    int             j;

    assign stall     = rsp_valid & ~rsp_ready;
    assign xfer      = found & ~stall & reset;
    assign req_ready = xfer ? NREQ'(1) << gnt_id : '0;

    // Search starts at ptr and wraps, so the last granted requester goes last.
    always_comb begin
        found    = 1'b0;
        gnt_id   = '0;
        sel_in1  = '0;
        sel_in2  = '0;
        sel_ctl  = '0;
        sel_sign = 1'b0;
        j        = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req_valid[j]) begin
                found    = 1'b1;
                gnt_id   = IDW'(j);
                sel_in1  = req_in1[32*j +: 32];
                sel_in2  = req_in2[32*j +: 32];
                sel_ctl  = req_ctl[5*j +: 5];
                sel_sign = req_sign[j];
            end
        end
    end

`ifdef ALU_ILLEGAL_CHK_EN
    assign ill = !(sel_ctl inside {5'b00000, 5'b00001, 5'b00010, 5'b00110, 5'b00111,
                                   5'b01100, 5'b01101, 5'b10000, 5'b11000, 5'b11001});
`else
    assign ill = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr       <= '0;
            iss_v     <= 1'b0;
            iss_err   <= 1'b0;
            iss_id    <= '0;
            alu_in1   <= '0;
            alu_in2   <= '0;
            alu_ctl   <= '0;
            alu_sign  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
            rsp_err   <= 1'b0;
        end else if (!stall) begin
            iss_v     <= xfer;
            rsp_valid <= iss_v;
            if (xfer) begin
                alu_in1  <= sel_in1;
                alu_in2  <= sel_in2;
                alu_ctl  <= ill ? 5'b00000 : sel_ctl;
                alu_sign <= sel_sign;
                iss_id   <= gnt_id;
                iss_err  <= ill;
                ptr      <= gnt_id == IDW'(NREQ - 1) ? '0 : gnt_id + IDW'(1);
            end
            if (iss_v) begin
                rsp_data <= iss_err ? 32'h0 : alu_out;
                rsp_zero <= iss_err | alu_zero;
                rsp_err  <= iss_err;
                rsp_id   <= iss_id;
            end
        end
    end
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter: directed checks of arbitration, pipeline, backpressure and reset.
// Exercises the ALU_ILLEGAL_CHK_EN path when that macro is defined.
module tb_alu_rr_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 3;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_in1 = '0;
    logic [NREQ*32-1:0] req_in2 = '0;
    logic [NREQ*5-1:0]  req_ctl = '0;
    logic [NREQ-1:0]    req_sign = '0;
    logic [31:0]        alu_in1, alu_in2, alu_out;
    logic [4:0]         alu_ctl;
    logic               alu_sign, alu_zero;
    logic               rsp_valid;
    logic               rsp_ready = 1'b1;
    logic [IDW-1:0]     rsp_id;
    logic [31:0]        rsp_data;
    logic               rsp_zero, rsp_err;
    int                 checks = 0;
    int                 errors = 0;

    always #5 clk = ~clk;

    alu_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_in1(req_in1), .req_in2(req_in2), .req_ctl(req_ctl), .req_sign(req_sign),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctl(alu_ctl), .alu_sign(alu_sign),
        .alu_out(alu_out), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
    );

    // Small stand-in for the external ALU: and/or/add/sub/slt.
    assign alu_out = alu_ctl == 5'b00000 ? alu_in1 & alu_in2 :
                     alu_ctl == 5'b00001 ? alu_in1 | alu_in2 :
                     alu_ctl == 5'b00010 ? alu_in1 + alu_in2 :
                     alu_ctl == 5'b00110 ? alu_in1 - alu_in2 :
                     alu_ctl == 5'b00111 ? {31'b0, alu_sign ? $signed(alu_in1) < $signed(alu_in2)
                                                            : alu_in1 < alu_in2} :
                     32'h0;
    assign alu_zero = alu_out == 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] c, input logic s);
        req_in1[32*i +: 32] = a;
        req_in2[32*i +: 32] = b;
        req_ctl[5*i +: 5]   = c;
        req_sign[i]         = s;
        req_valid[i]        = 1'b1;
    endtask

    task automatic do_reset;
        req_valid = '0;
        reset = 1'b0;
        tick;
        tick;
        reset = 1'b1;
        #1;
    endtask

    initial begin
        // Reset with a pending request: nothing may be granted.
        set_req(0, 32'd9, 32'd9, 5'b00010, 1'b0);
        tick;
        #1;
        chk("rst_ready", 32'(req_ready), 32'h0);
        tick;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_alu_in1", alu_in1, 32'h0);
        chk("rst_alu_ctl", 32'(alu_ctl), 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        req_valid = '0;
        reset = 1'b1;
        #1;

        // Single request: 5 + 3.
        set_req(0, 32'd5, 32'd3, 5'b00010, 1'b0);
        #1;
        chk("single_ready", 32'(req_ready), 32'b0001);
        tick;
        req_valid = '0;
        #1;
        chk("single_alu_in1", alu_in1, 32'd5);
        chk("single_alu_in2", alu_in2, 32'd3);
        chk("single_not_yet", 32'(rsp_valid), 32'h0);
        tick;
        chk("single_valid", 32'(rsp_valid), 32'h1);
        chk("single_id", 32'(rsp_id), 32'h0);
        chk("single_data", rsp_data, 32'd8);
        chk("single_zero", 32'(rsp_zero), 32'h0);
        chk("single_err", 32'(rsp_err), 32'h0);
        tick;
        chk("single_drained", 32'(rsp_valid), 32'h0);

        // Fairness: all four continuously valid, one response per cycle.
        do_reset;
        for (int i = 0; i < NREQ; i++) set_req(i, 32'(i), 32'd100, 5'b00010, 1'b0);
        #1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("fair_ready%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
            if (k >= 2) begin
                chk($sformatf("fair_valid%0d", k), 32'(rsp_valid), 32'h1);
                chk($sformatf("fair_id%0d", k), 32'(rsp_id), 32'((k - 2) % 4));
                chk($sformatf("fair_data%0d", k), rsp_data, 32'(100 + (k - 2) % 4));
            end
            tick;
        end
        req_valid = '0;
        tick;
        tick;
        chk("fair_drained", 32'(rsp_valid), 32'h0);

        // Backpressure: response held for 5 cycles, pending request not granted.
        do_reset;
        rsp_ready = 1'b0;
        set_req(0, 32'd7, 32'd1, 5'b00110, 1'b0);
        set_req(1, 32'hF0, 32'h3C, 5'b00000, 1'b0);
        #1;
        chk("bp_ready0", 32'(req_ready), 32'b0001);
        tick;
        req_valid[0] = 1'b0;
        #1;
        chk("bp_ready1", 32'(req_ready), 32'b0010);
        tick;
        req_valid[1] = 1'b0;
        set_req(2, 32'd1, 32'd1, 5'b00010, 1'b0);
        #1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_hold_ready%0d", k), 32'(req_ready), 32'h0);
            chk($sformatf("bp_hold_valid%0d", k), 32'(rsp_valid), 32'h1);
            chk($sformatf("bp_hold_data%0d", k), rsp_data, 32'd6);
            tick;
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_rel_ready", 32'(req_ready), 32'b0100);
        chk("bp_rel_id0", 32'(rsp_id), 32'h0);
        tick;
        req_valid[2] = 1'b0;
        #1;
        chk("bp_rsp1_valid", 32'(rsp_valid), 32'h1);
        chk("bp_rsp1_id", 32'(rsp_id), 32'h1);
        chk("bp_rsp1_data", rsp_data, 32'h30);
        tick;
        chk("bp_rsp2_valid", 32'(rsp_valid), 32'h1);
        chk("bp_rsp2_id", 32'(rsp_id), 32'h2);
        chk("bp_rsp2_data", rsp_data, 32'd2);
        tick;
        chk("bp_drained", 32'(rsp_valid), 32'h0);

        // Signed versus unsigned compare on requester 2.
        do_reset;
        set_req(2, 32'hFFFF_FFFF, 32'h1, 5'b00111, 1'b1);
        tick;
        req_valid = '0;
        tick;
        chk("slt_s_id", 32'(rsp_id), 32'h2);
        chk("slt_s_data", rsp_data, 32'h1);
        chk("slt_s_zero", 32'(rsp_zero), 32'h0);
        set_req(2, 32'hFFFF_FFFF, 32'h1, 5'b00111, 1'b0);
        #1;
        chk("slt_u_ready", 32'(req_ready), 32'b0100);
        tick;
        req_valid = '0;
        tick;
        chk("slt_u_data", rsp_data, 32'h0);
        chk("slt_u_zero", 32'(rsp_zero), 32'h1);

        // Reset with issue and response both occupied.
        set_req(0, 32'd1, 32'd2, 5'b00010, 1'b0);
        set_req(1, 32'd3, 32'd4, 5'b00010, 1'b0);
        tick;
        tick;
        req_valid = '0;
        #1;
        chk("mid_pre_valid", 32'(rsp_valid), 32'h1);
        set_req(3, 32'd40, 32'd2, 5'b00010, 1'b0);
        reset = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'h0);
        tick;
        chk("mid_rst_valid", 32'(rsp_valid), 32'h0);
        chk("mid_rst_ready2", 32'(req_ready), 32'h0);
        reset = 1'b1;
        #1;
        chk("mid_req3_ready", 32'(req_ready), 32'b1000);
        tick;
        req_valid = '0;
        #1;
        chk("mid_no_stale", 32'(rsp_valid), 32'h0);
        chk("mid_alu_in1", alu_in1, 32'd40);
        tick;
        chk("mid_req3_valid", 32'(rsp_valid), 32'h1);
        chk("mid_req3_id", 32'(rsp_id), 32'h3);
        chk("mid_req3_data", rsp_data, 32'd42);
        tick;

`ifdef ALU_ILLEGAL_CHK_EN
        set_req(1, 32'd5, 32'd6, 5'b00011, 1'b0);
        tick;
        req_valid = '0;
        #1;
        chk("ill_alu_ctl", 32'(alu_ctl), 32'h0);
        tick;
        chk("ill_valid", 32'(rsp_valid), 32'h1);
        chk("ill_err", 32'(rsp_err), 32'h1);
        chk("ill_data", rsp_data, 32'h0);
        chk("ill_zero", 32'(rsp_zero), 32'h1);
        chk("ill_id", 32'(rsp_id), 32'h1);
`else
        set_req(1, 32'd5, 32'd6, 5'b00011, 1'b0);
        tick;
        req_valid = '0;
        #1;
        chk("pass_alu_ctl", 32'(alu_ctl), 32'b00011);
        tick;
        chk("pass_err", 32'(rsp_err), 32'h0);
        chk("pass_id", 32'(rsp_id), 32'h1);
`endif
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
